// File: rtl/arm_datapath.sv
// arm_datapath: single-cycle ARM-style datapath (regfile, ALU, flags, byte-addressed data memory).
// Define ARM_DATAPATH_MOVK_EN to enable the MOVK operand-B merge path.
module arm_datapath #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        Reg2Loc,
  input  logic        ALUSrc,
  input  logic        imm12Cntrl,
  input  logic        movKCntrl,
  input  logic [2:0]  ALUop,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        byteLoader,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [3:0]  xfer_size,
  input  logic        flagSignal,
  output logic        negativeAlu,
  output logic        zeroAlu,
  output logic        overflowAlu,
  output logic        carryOutAlu,
  output logic        zeroCurr
);
  localparam int AW = $clog2(MEM_BYTES);
  logic [63:0] regs [32];
  logic [7:0]  mem [MEM_BYTES];
  logic [4:0]  rd, rn, ra2;
  logic [5:0]  sh;
  logic [63:0] rd1, rd2, movz, opb_sel, opb, addend, res, rdata, wb;
  logic [64:0] sum;
  logic        sub, arith, ovf, ok;
  logic [AW-1:0] addr;
  logic        unused_bits;
  assign rd  = Instruction[4:0];
  assign rn  = Instruction[9:5];
  assign ra2 = Reg2Loc ? Instruction[20:16] : rd;
  assign sh  = {Instruction[22:21], 4'b0};
  assign rd1 = rn == 5'd31 ? '0 : regs[rn];
  assign rd2 = ra2 == 5'd31 ? '0 : regs[ra2];
  assign movz = {48'b0, Instruction[20:5]} << sh;
  assign opb_sel = {imm12Cntrl, ALUSrc} == 2'b00 ? rd2 :
                   {imm12Cntrl, ALUSrc} == 2'b01 ? {{55{Instruction[20]}}, Instruction[20:12]} :
                   {imm12Cntrl, ALUSrc} == 2'b10 ? {52'b0, Instruction[21:10]} : movz;
`ifdef ARM_DATAPATH_MOVK_EN
  assign opb = movKCntrl ? ((rd2 & ~(64'hFFFF << sh)) | movz) : opb_sel;
  assign unused_bits = ^Instruction[31:23];
`else
  assign opb = opb_sel;
  assign unused_bits = ^{Instruction[31:23], movKCntrl};
`endif
  assign sub    = ALUop == 3'b011;
  assign arith  = ALUop == 3'b010 || sub;
  assign addend = sub ? ~opb : opb;
  assign sum    = {1'b0, rd1} + {1'b0, addend} + {64'b0, sub};
  assign ovf    = (rd1[63] == addend[63]) && (sum[63] != rd1[63]);
  assign res = ALUop == 3'b000 ? opb :
               arith           ? sum[63:0] :
               ALUop == 3'b100 ? rd1 & opb :
               ALUop == 3'b101 ? rd1 | opb :
               ALUop == 3'b110 ? rd1 ^ opb : '0;
  assign zeroCurr = res == '0;
  // only naturally aligned 1/2/4/8-byte transfers touch memory
  assign addr = res[AW-1:0];
  assign ok = (xfer_size == 4'd1 || xfer_size == 4'd2 || xfer_size == 4'd4 || xfer_size == 4'd8) &&
              (addr & AW'(xfer_size - 4'd1)) == '0;
  always_comb begin
    rdata = '0;
    if (read_enable && ok)
      for (int i = 0; i < 8; i++)
        if (i < int'(xfer_size)) rdata[8*i +: 8] = mem[addr + AW'(i)];
  end
  assign wb = MemtoReg ? (byteLoader ? rdata : {56'b0, rdata[7:0]}) : res;
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      {negativeAlu, zeroAlu, carryOutAlu, overflowAlu} <= '0;
    end else begin
      if (RegWrite && rd != 5'd31) regs[rd] <= wb;
      if (flagSignal) {negativeAlu, zeroAlu, carryOutAlu, overflowAlu} <= {res[63], zeroCurr, arith & sum[64], arith & ovf};
    end
  end
  always_ff @(posedge clk)
    if (reset && write_enable && ok)
      for (int i = 0; i < 8; i++)
        if (i < int'(xfer_size)) mem[addr + AW'(i)] <= rd2[8*i +: 8];
endmodule

// File: tb/tb_arm_datapath.sv
// tb_arm_datapath: directed scoreboard bench for arm_datapath (handles either MOVK build).
module tb_arm_datapath;
  logic clk = 0, reset = 0;
  logic [31:0] Instruction = '0;
  logic Reg2Loc = 0, ALUSrc = 0, imm12Cntrl = 0, movKCntrl = 0, RegWrite = 0, MemtoReg = 0;
  logic byteLoader = 0, write_enable = 0, read_enable = 0, flagSignal = 0;
  logic [2:0] ALUop = '0;
  logic [3:0] xfer_size = 4'd8;
  logic negativeAlu, zeroAlu, overflowAlu, carryOutAlu, zeroCurr;
  int passes = 0, total = 0;
  typedef struct { string tag; logic [63:0] exp; } exp_t;
  exp_t q[$];
  logic [63:0] x5v;

  arm_datapath #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
    .imm12Cntrl(imm12Cntrl), .movKCntrl(movKCntrl), .ALUop(ALUop), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .byteLoader(byteLoader), .write_enable(write_enable),
    .read_enable(read_enable), .xfer_size(xfer_size), .flagSignal(flagSignal),
    .negativeAlu(negativeAlu), .zeroAlu(zeroAlu), .overflowAlu(overflowAlu),
    .carryOutAlu(carryOutAlu), .zeroCurr(zeroCurr));

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [4:0] d, n, m);
    return {11'b0, m, 6'b0, n, d};
  endfunction
  function automatic logic [31:0] i_ins(input logic [4:0] d, n, input logic [11:0] imm);
    return {10'b0, imm, n, d};
  endfunction
  function automatic logic [31:0] d_ins(input logic [4:0] d, n, input logic [8:0] imm);
    return {11'b0, imm, 2'b0, n, d};
  endfunction
  function automatic logic [31:0] w_ins(input logic [4:0] d, input logic [15:0] imm, input logic [1:0] hw);
    return {9'b0, hw, imm, d};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic r2l, input logic [1:0] sel, input logic mk,
                       input logic [2:0] op, input logic rw, m2r, bl, we, re, input logic [3:0] xs, input logic fl);
    Instruction = ins; Reg2Loc = r2l; {imm12Cntrl, ALUSrc} = sel; movKCntrl = mk; ALUop = op;
    RegWrite = rw; MemtoReg = m2r; byteLoader = bl; write_enable = we; read_enable = re;
    xfer_size = xs; flagSignal = fl;
  endtask
  task automatic tick();
    @(posedge clk); #1;
    RegWrite = 0; write_enable = 0; flagSignal = 0; movKCntrl = 0;
  endtask
  task automatic push(input string tag, input logic [63:0] e);
    q.push_back('{tag, e});
  endtask
  task automatic chk(input logic [63:0] obs);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = q.pop_front();
    assert (obs === e.exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
  endtask
  function automatic logic [63:0] flags();
    return {60'b0, negativeAlu, zeroAlu, carryOutAlu, overflowAlu};
  endfunction

  initial begin
`ifdef ARM_DATAPATH_MOVK_EN
    x5v = 64'h00000000BEEF1234;
`else
    x5v = 64'h0000000000001234;
`endif
    push("reset_flags", 0); push("reset_x1", 0);
    tick();
    chk(flags()); chk(dut.regs[1]);
    reset = 1;
    push("addi_x1", 1);
    drive(i_ins(1, 0, 1), 0, 2'b10, 0, 3'b010, 1, 0, 0, 0, 0, 8, 0); tick();
    chk(dut.regs[1]);
    push("subs_x3", '1); push("subs_flags", 64'b1000);
    drive(r_ins(3, 0, 1), 1, 2'b00, 0, 3'b011, 1, 0, 0, 0, 0, 8, 1); tick();
    chk(dut.regs[3]); chk(flags());
    push("movz_x5", 64'hBEEF0000);
    drive(w_ins(5, 16'hBEEF, 1), 0, 2'b11, 0, 3'b000, 1, 0, 0, 0, 0, 8, 0); tick();
    chk(dut.regs[5]);
    push("movk_x5", x5v);
    drive(w_ins(5, 16'h1234, 0), 0, 2'b11, 1, 3'b000, 1, 0, 0, 0, 0, 8, 0); tick();
    chk(dut.regs[5]);
    drive(d_ins(5, 31, 8), 0, 2'b01, 0, 3'b010, 0, 0, 0, 1, 0, 8, 0); tick();
    push("ldur_byte", x5v & 64'hFF);
    drive(d_ins(6, 31, 8), 0, 2'b01, 0, 3'b010, 1, 1, 0, 0, 1, 8, 0); tick();
    chk(dut.regs[6]);
    push("ldur_full", x5v);
    drive(d_ins(6, 31, 8), 0, 2'b01, 0, 3'b010, 1, 1, 1, 0, 1, 8, 0); tick();
    chk(dut.regs[6]);
    push("subs_zerocurr", 1); push("subs_zero_flags", 64'b0110); push("subs_x7", 0);
    drive(r_ins(7, 1, 1), 1, 2'b00, 0, 3'b011, 1, 0, 0, 0, 0, 8, 1); #1;
    chk(zeroCurr); tick();
    chk(flags()); chk(dut.regs[7]);
    push("nonzero_zerocurr", 0); push("flags_hold", 64'b0110); push("addi_x8", 2);
    drive(i_ins(8, 1, 1), 0, 2'b10, 0, 3'b010, 1, 0, 0, 0, 0, 8, 0); #1;
    chk(zeroCurr); tick();
    chk(flags()); chk(dut.regs[8]);
    push("x31_write_ignored", 0); push("x31_reads_zero", 1);
    drive(i_ins(31, 1, 5), 0, 2'b10, 0, 3'b010, 1, 0, 0, 0, 0, 8, 0); tick();
    chk(dut.regs[31]);
    drive(r_ins(0, 0, 31), 1, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0, 8, 0); #1;
    chk(zeroCurr);
    drive(d_ins(1, 31, 4), 0, 2'b01, 0, 3'b010, 0, 0, 0, 1, 0, 8, 0); tick();
    push("misaligned_store_nochange", x5v);
    drive(d_ins(12, 31, 8), 0, 2'b01, 0, 3'b010, 1, 1, 1, 0, 1, 8, 0); tick();
    chk(dut.regs[12]);
    push("misaligned_load_zero", 0);
    drive(d_ins(13, 31, 4), 0, 2'b01, 0, 3'b010, 1, 1, 1, 0, 1, 8, 0); tick();
    chk(dut.regs[13]);
    push("illegal_size_zero", 0);
    drive(d_ins(14, 31, 8), 0, 2'b01, 0, 3'b010, 1, 1, 1, 0, 1, 3, 0); tick();
    chk(dut.regs[14]);
    push("read_disabled_zero", 0);
    drive(d_ins(15, 31, 8), 0, 2'b01, 0, 3'b010, 1, 1, 1, 0, 0, 8, 0); tick();
    chk(dut.regs[15]);
    push("movz_hw3", 64'h8000000000000000);
    drive(w_ins(9, 16'h8000, 3), 0, 2'b11, 0, 3'b000, 1, 0, 0, 0, 0, 8, 0); tick();
    chk(dut.regs[9]);
    push("adds_ovf_x10", 0); push("adds_ovf_flags", 64'b0111);
    drive(r_ins(10, 9, 9), 1, 2'b00, 0, 3'b010, 1, 0, 0, 0, 0, 8, 1); tick();
    chk(dut.regs[10]); chk(flags());
    push("orr_x11", x5v | 64'h8000000000000000);
    drive(r_ins(11, 5, 9), 1, 2'b00, 0, 3'b101, 1, 0, 0, 0, 0, 8, 0); tick();
    chk(dut.regs[11]);
    push("eor_x4", x5v ^ 64'h1);
    drive(r_ins(4, 5, 1), 1, 2'b00, 0, 3'b110, 1, 0, 0, 0, 0, 8, 0); tick();
    chk(dut.regs[4]);
    push("subi_neg9", 64'd10);
    drive(d_ins(2, 1, 9'h1F7), 0, 2'b01, 0, 3'b011, 1, 0, 0, 0, 0, 8, 0); tick();
    chk(dut.regs[2]);
    push("rst_x1", 0); push("rst_x9", 0); push("rst_flags", 0);
    reset = 0;
    drive(d_ins(9, 31, 8), 0, 2'b01, 0, 3'b010, 1, 0, 0, 1, 0, 8, 1); tick();
    chk(dut.regs[1]); chk(dut.regs[9]); chk(flags());
    reset = 1;
    push("rst_mem_kept", x5v);
    drive(d_ins(2, 31, 8), 0, 2'b01, 0, 3'b010, 1, 1, 1, 0, 1, 8, 0); tick();
    chk(dut.regs[2]);
    if (q.size() != 0) begin
      total++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
